// File: rtl/blit_pkg.sv
// Shared types for the blit command queue: command record, sequencer states and
// the blit bounds rule used to reject commands before they reach the write engine.
package blit_pkg;

    localparam int DEF_FB_W = 256;
    localparam int DEF_FB_H = 240;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic   fence;
        coord_t sramx;
        coord_t sramy;
        coord_t startx;
        coord_t starty;
        coord_t sizex;
        coord_t sizey;
    } blit_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_RELEASE,
        S_FENCE
    } bq_state_t;

    // Sums are widened to 11 bits so a large origin plus a large size cannot wrap.
    function automatic logic blit_ok(blit_cmd_t c, int fb_w, int fb_h);
        logic [10:0] end_x;
        logic [10:0] end_y;
        end_x = {1'b0, c.startx} + {1'b0, c.sizex};
        end_y = {1'b0, c.starty} + {1'b0, c.sizey};
        return (c.sizex != '0) && (c.sizey != '0) &&
               (end_x <= 11'(fb_w)) && (end_y <= 11'(fb_h));
    endfunction

endpackage

// File: rtl/blit_queue_if.sv
// Command push port from the NIOS and start/done operand port to fb_controller.
interface blit_queue_if;
    import blit_pkg::*;

    logic   cmd_valid;
    logic   cmd_ready;
    logic   cmd_fence;
    coord_t cmd_sramx;
    coord_t cmd_sramy;
    coord_t cmd_startx;
    coord_t cmd_starty;
    coord_t cmd_sizex;
    coord_t cmd_sizey;

    logic   fb_start;
    coord_t fb_sramx;
    coord_t fb_sramy;
    coord_t fb_startx;
    coord_t fb_starty;
    coord_t fb_sizex;
    coord_t fb_sizey;
    logic   fb_done;

    modport master (
        output cmd_valid, cmd_fence, cmd_sramx, cmd_sramy,
               cmd_startx, cmd_starty, cmd_sizex, cmd_sizey,
        input  cmd_ready,
        input  fb_start, fb_sramx, fb_sramy, fb_startx, fb_starty, fb_sizex, fb_sizey,
        output fb_done
    );

    modport slave (
        input  cmd_valid, cmd_fence, cmd_sramx, cmd_sramy,
               cmd_startx, cmd_starty, cmd_sizex, cmd_sizey,
        output cmd_ready,
        output fb_start, fb_sramx, fb_sramy, fb_startx, fb_starty, fb_sizex, fb_sizey,
        input  fb_done
    );

endinterface

// File: rtl/blit_fifo.sv
// Show-ahead synchronous FIFO of blit commands with a single-cycle flush.
module blit_fifo
    import blit_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  blit_cmd_t wdata,
    output blit_cmd_t rdata,
    output logic      full,
    output logic      empty,
    output logic [AW:0] level
);

    blit_cmd_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which entries are live, and resetting the array would cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/blit_queue.sv
// Sprite-blit command queue: pops commands, rejects out-of-bounds blits, stalls on
// frame fences and runs the fb_controller start/done handshake with held operands.
module blit_queue
    import blit_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int FB_W  = DEF_FB_W,
    parameter  int FB_H  = DEF_FB_H,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    blit_queue_if.slave   bus,
    input  logic          flush,
    input  logic          frame_sync,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic [15:0]   blit_count,
    output logic [7:0]    drop_count
);

    bq_state_t state;
    blit_cmd_t wcmd;
    blit_cmd_t head;
    blit_cmd_t cur;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      fs_q;
    logic      start_q;

    assign wcmd = '{fence:  bus.cmd_fence,
                    sramx:  bus.cmd_sramx,
                    sramy:  bus.cmd_sramy,
                    startx: bus.cmd_startx,
                    starty: bus.cmd_starty,
                    sizex:  bus.cmd_sizex,
                    sizey:  bus.cmd_sizey};

    // Ready is held low while RESET is asserted so it first rises once reset lifts.
    assign bus.cmd_ready = !RESET && !full && !flush;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == S_IDLE) && !empty && !flush;
    assign busy          = (state != S_IDLE) || !empty;

    assign bus.fb_start  = start_q;
    assign bus.fb_sramx  = cur.sramx;
    assign bus.fb_sramy  = cur.sramy;
    assign bus.fb_startx = cur.startx;
    assign bus.fb_starty = cur.starty;
    assign bus.fb_sizex  = cur.sizex;
    assign bus.fb_sizey  = cur.sizey;

    blit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the pre-edge values, matching real flip-flop behaviour.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cur        <= '0;
            start_q    <= 1'b0;
            blit_count <= '0;
            drop_count <= '0;
            fs_q       <= 1'b0;
        end else begin
            fs_q <= frame_sync;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur   <= head;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cur.fence) begin
                        state <= S_FENCE;
                    end else if (!blit_ok(cur, FB_W, FB_H)) begin
                        if (drop_count != 8'hFF)
                            drop_count <= drop_count + 8'd1;
                        state <= S_IDLE;
                    end else begin
                        start_q <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.fb_done) begin
                        start_q <= 1'b0;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!bus.fb_done) begin
                        blit_count <= blit_count + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                // Only falls sampled while already waiting count; no edge is remembered.
                S_FENCE: begin
                    if (fs_q && !frame_sync)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_queue.sv
// Directed bench for blit_queue: an in-order command scoreboard checks operands on
// every issued cycle, and directed steps pin latency, counters, fences and flush.
module tb_blit_queue;
    import blit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       frame_sync = 1'b0;
    logic [4:0] level;
    logic       busy;
    logic [15:0] blit_count;
    logic [7:0] drop_count;

    blit_queue_if bus ();

    blit_queue #(.DEPTH(16), .FB_W(256), .FB_H(240)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .bus        (bus),
        .flush      (flush),
        .frame_sync (frame_sync),
        .level      (level),
        .busy       (busy),
        .blit_count (blit_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_valid(blit_cmd_t c);
        int ex;
        int ey;
        ex = int'(c.startx) + int'(c.sizex);
        ey = int'(c.starty) + int'(c.sizey);
        return (c.sizex != 0) && (c.sizey != 0) && (ex <= 256) && (ey <= 240);
    endfunction

    // ---------------- fb_controller stand-in ----------------
    int done_delay = 2;
    bit hold_done  = 1'b0;
    int completions = 0;

    initial begin
        int cnt;
        cnt = 0;
        bus.fb_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.fb_done = 1'b0;
                cnt = 0;
                completions = 0;
            end else if (!bus.fb_done) begin
                if (bus.fb_start && !hold_done) begin
                    cnt++;
                    if (cnt >= done_delay) begin
                        bus.fb_done = 1'b1;
                        cnt = 0;
                    end
                end
            end else if (!bus.fb_start) begin
                bus.fb_done = 1'b0;
                completions++;
            end
        end
    end

    // ---------------- scoreboard and per-cycle compare ----------------
    blit_cmd_t model_q[$];
    blit_cmd_t exp_cur;
    int  exp_drops  = 0;
    int  start_rises = 0;
    bit  prev_start = 1'b0;

    initial begin
        blit_cmd_t c;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_fb_start", bus.fb_start, 0);
                check("rst_level", level, 0);
                check("rst_ready", bus.cmd_ready, 0);
                model_q.delete();
                exp_drops = 0;
                prev_start = 1'b0;
            end else begin
                check("ready_rule", bus.cmd_ready, (level != 5'd16) && !flush);
                check("level_range", level <= 5'd16, 1);
                if (bus.fb_start && !prev_start) begin
                    start_rises++;
                    while (model_q.size() > 0 && (model_q[0].fence || !tb_valid(model_q[0])))
                        void'(model_q.pop_front());
                    check("start_has_cmd", model_q.size() > 0, 1);
                    if (model_q.size() > 0)
                        exp_cur = model_q.pop_front();
                end
                if (bus.fb_start)
                    check("fb_operands",
                          {bus.fb_sramx, bus.fb_sramy, bus.fb_startx,
                           bus.fb_starty, bus.fb_sizex, bus.fb_sizey},
                          {exp_cur.sramx, exp_cur.sramy, exp_cur.startx,
                           exp_cur.starty, exp_cur.sizex, exp_cur.sizey});
                prev_start = bus.fb_start;
                if (flush) begin
                    foreach (model_q[i])
                        if (!model_q[i].fence && !tb_valid(model_q[i]))
                            exp_drops--;
                    model_q.delete();
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    c = '{fence: bus.cmd_fence, sramx: bus.cmd_sramx, sramy: bus.cmd_sramy,
                          startx: bus.cmd_startx, starty: bus.cmd_starty,
                          sizex: bus.cmd_sizex, sizey: bus.cmd_sizey};
                    model_q.push_back(c);
                    if (!c.fence && !tb_valid(c) && exp_drops < 255)
                        exp_drops++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_cmd(input bit fence, input int sx, input int sy,
                           input int x, input int y, input int w, input int h);
        bus.cmd_fence  = fence;
        bus.cmd_sramx  = 10'(sx);
        bus.cmd_sramy  = 10'(sy);
        bus.cmd_startx = 10'(x);
        bus.cmd_starty = 10'(y);
        bus.cmd_sizex  = 10'(w);
        bus.cmd_sizey  = 10'(h);
    endtask

    task automatic push_cmd(input bit fence, input int sx, input int sy,
                            input int x, input int y, input int w, input int h);
        int n;
        set_cmd(fence, sx, sy, x, y, w, h);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            tick();
            n++;
        end
        check("push_accept", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check("reach_idle", busy, 0);
    endtask

    task automatic wait_start(input int bound);
        int n;
        n = 0;
        while (!bus.fb_start && n < bound) begin
            tick();
            n++;
        end
        check("start_seen", bus.fb_start, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int base;
        bus.cmd_valid = 1'b0;
        set_cmd(1'b0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick();
        check("post_reset_ready", bus.cmd_ready, 1);
        check("post_reset_level", level, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_counts", {blit_count, drop_count}, 0);

        // Single blit, 3-cycle start latency, long fb_controller busy time.
        done_delay = 300;
        push_cmd(1'b0, 0, 0, 10, 20, 16, 16);
        check("lat_c1", bus.fb_start, 0);
        tick();
        check("lat_c2", bus.fb_start, 0);
        tick();
        check("lat_c3", bus.fb_start, 1);
        check("single_operands",
              {bus.fb_sramx, bus.fb_sramy, bus.fb_startx, bus.fb_starty, bus.fb_sizex, bus.fb_sizey},
              {10'd0, 10'd0, 10'd10, 10'd20, 10'd16, 10'd16});
        n = 0;
        while (!bus.fb_done && n < 400) begin
            tick();
            n++;
        end
        check("done_seen", bus.fb_done, 1);
        check("start_falls", bus.fb_start, 0);
        wait_idle(50);
        check("single_blit_count", blit_count, 1);
        check("single_model_count", blit_count, 16'(completions));

        // Rejection, including both bounds exactly at the framebuffer edge.
        done_delay = 2;
        base = start_rises;
        push_cmd(1'b0, 0, 0, 0, 0, 0, 5);
        wait_idle(50);
        check("drop_size0", drop_count, 1);
        push_cmd(1'b0, 0, 0, 250, 0, 16, 4);
        wait_idle(50);
        check("drop_x_over", drop_count, 2);
        push_cmd(1'b0, 0, 0, 0, 225, 1, 16);
        wait_idle(50);
        check("drop_y_over", drop_count, 3);
        check("no_start_on_drop", start_rises, base);
        push_cmd(1'b0, 3, 4, 240, 224, 16, 16);
        wait_idle(50);
        check("edge_blit_issued", blit_count, 2);
        check("edge_drop_same", drop_count, 3);
        check("drop_model", drop_count, 8'(exp_drops));

        // Fence: a fall before the fence is reached must not release it.
        done_delay = 20;
        base = start_rises;
        push_cmd(1'b0, 1, 1, 0, 0, 8, 8);
        push_cmd(1'b1, 0, 0, 0, 0, 0, 0);
        push_cmd(1'b0, 2, 2, 100, 50, 8, 8);
        tick(2);
        frame_sync = 1'b1;
        tick(2);
        frame_sync = 1'b0;
        n = 0;
        while (blit_count != 16'd3 && n < 200) begin
            tick();
            n++;
        end
        check("fence_a_done", blit_count, 3);
        tick(10);
        check("fence_holds", bus.fb_start, 0);
        check("fence_busy", busy, 1);
        check("fence_one_start", start_rises, base + 1);
        frame_sync = 1'b1;
        tick(3);
        check("fence_rise_ignored", start_rises, base + 1);
        frame_sync = 1'b0;
        tick(2);
        check("fence_b_not_yet", bus.fb_start, 0);
        tick();
        check("fence_b_start", bus.fb_start, 1);
        check("fence_b_x", bus.fb_startx, 100);
        wait_idle(100);
        check("fence_b_done", blit_count, 4);

        // Full queue with the engine held busy.
        done_delay = 2;
        hold_done = 1'b1;
        for (int i = 0; i < 17; i++)
            push_cmd(1'b0, 100 + i, 0, i, 0, 1, 1);
        set_cmd(1'b0, 117, 0, 17, 0, 1, 1);
        bus.cmd_valid = 1'b1;
        tick(3);
        check("full_ready_low", bus.cmd_ready, 0);
        check("full_level", level, 16);
        hold_done = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("full_ready_back", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("full_refill", level, 16);
        wait_idle(3000);
        check("full_blit_count", blit_count, 22);
        check("full_model_count", blit_count, 16'(completions));

        // Flush with a blit in flight and a push offered on the same cycle.
        hold_done = 1'b1;
        base = start_rises;
        push_cmd(1'b0, 5, 5, 30, 30, 4, 4);
        wait_start(20);
        for (int i = 0; i < 5; i++)
            push_cmd(1'b0, 200 + i, 0, 40 + i, 0, 2, 2);
        check("flush_pre_level", level, 5);
        flush = 1'b1;
        set_cmd(1'b0, 9, 9, 60, 60, 2, 2);
        bus.cmd_valid = 1'b1;
        #1;
        check("flush_refuses_push", bus.cmd_ready, 0);
        tick();
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_inflight", bus.fb_start, 1);
        hold_done = 1'b0;
        wait_idle(100);
        check("flush_blit_count", blit_count, 23);
        check("flush_one_start", start_rises, base + 1);
        check("flush_drops", drop_count, 3);

        // Reset in the middle of an issued blit.
        hold_done = 1'b1;
        push_cmd(1'b0, 7, 7, 70, 70, 4, 4);
        wait_start(20);
        push_cmd(1'b0, 8, 8, 80, 80, 4, 4);
        push_cmd(1'b0, 9, 9, 90, 90, 4, 4);
        rst = 1'b1;
        #1;
        check("rst_mid_start", bus.fb_start, 0);
        check("rst_mid_level", level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_counts", {blit_count, drop_count}, 0);
        tick(2);
        rst = 1'b0;
        hold_done = 1'b0;
        tick();
        check("rst_mid_ready", bus.cmd_ready, 1);
        push_cmd(1'b0, 1, 2, 3, 4, 5, 6);
        wait_idle(100);
        check("after_rst_count", blit_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
